// File: rtl/event_latch_pkg.sv
// Shared constants for the seven-channel event latch and its priority encoder.
package event_latch_pkg;

  localparam int          CHANNELS   = 7;
  localparam int          INDEX_W    = 8;
  localparam logic [7:0]  INDEX_NONE = 8'd0;
  localparam logic [6:0]  MASK_RESET = 7'h7F;

endpackage

// File: rtl/event_latch_prio_enc7.sv
// Lowest-channel-first priority encoder: 1-based channel index (0 = none) plus valid.
// Purely combinational.
module prio_enc7
  import event_latch_pkg::*;
#(
  parameter int unsigned UUID = 0
) (
  input  logic [CHANNELS-1:0] req,
  output logic [INDEX_W-1:0]  index,
  output logic                valid
);

  logic unused_uuid;
  assign unused_uuid = ^UUID;

  // Scan from the top down so the lowest set channel is the last to write.
  always_comb begin
    index = INDEX_NONE;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) index = INDEX_W'(i + 1);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/event_latch_7ch.sv
// Seven-channel sticky event capture with enable mask, priority index and one-per-cycle Ack.
// Build option EVENT_LATCH_LEVEL_EN selects level capture (no edge detect, Lost tied 0).
module event_latch_7ch
  import event_latch_pkg::*;
#(
  parameter int unsigned UUID = 0,
  parameter string       NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Req_1,
  input  logic       Req_2,
  input  logic       Req_3,
  input  logic       Req_4,
  input  logic       Req_5,
  input  logic       Req_6,
  input  logic       Req_7,
  input  logic       Mask_Load,
  input  logic [7:0] Mask_Data,
  input  logic       Ack,
  input  logic       Clear_Lost,
  output logic       Pending_1,
  output logic       Pending_2,
  output logic       Pending_3,
  output logic       Pending_4,
  output logic       Pending_5,
  output logic       Pending_6,
  output logic       Pending_7,
  output logic       Valid,
  output logic [7:0] Index,
  output logic       Lost
);

  localparam bit HAS_NAME = (NAME != "");

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] set_vec;
  logic [CHANNELS-1:0] clr_vec;
  logic [CHANNELS-1:0] pend_nxt;
  logic [INDEX_W-1:0]  index;
  logic                valid;

  assign req     = {Req_7, Req_6, Req_5, Req_4, Req_3, Req_2, Req_1};
  assign pending = pend & mask;

  prio_enc7 #(
    .UUID (UUID ^ 32'd1)
  ) u_prio (
    .req   (pending),
    .index (index),
    .valid (valid)
  );

  // Ack retires exactly the channel currently shown on Index (old mask).
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clr_vec[i] = Ack && valid && (index == INDEX_W'(i + 1));
    end
  end

  // A set on the same channel as a clear wins.
  assign pend_nxt = (pend & ~clr_vec) | set_vec;

`ifdef EVENT_LATCH_LEVEL_EN
  logic unused_cfg;
  assign unused_cfg = ^{UUID, HAS_NAME, Mask_Data[7], Clear_Lost};
  assign set_vec    = req;
  assign Lost       = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      mask <= MASK_RESET;
    end else begin
      pend <= pend_nxt;
      if (Mask_Load) mask <= Mask_Data[CHANNELS-1:0];
    end
  end
`else
  logic [CHANNELS-1:0] req_q;
  logic                lost;
  logic                lost_set;
  logic unused_cfg;
  assign unused_cfg = ^{UUID, HAS_NAME, Mask_Data[7]};

  assign set_vec  = req & ~req_q;
  assign lost_set = |(set_vec & pend & ~clr_vec);
  assign Lost     = lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      mask  <= MASK_RESET;
      req_q <= '0;
      lost  <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      req_q <= req;
      if (Mask_Load) mask <= Mask_Data[CHANNELS-1:0];
      if (lost_set)        lost <= 1'b1;
      else if (Clear_Lost) lost <= 1'b0;
    end
  end
`endif

  assign {Pending_7, Pending_6, Pending_5, Pending_4, Pending_3, Pending_2, Pending_1} = pending;
  assign Valid = valid;
  assign Index = index;

endmodule

// File: tb/tb_event_latch_7ch.sv
// Scoreboard bench for event_latch_7ch: directed scenarios then random traffic against a channel-array model.
module tb_event_latch_7ch;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] rq;
  logic       Mask_Load;
  logic [7:0] Mask_Data;
  logic       Ack;
  logic       Clear_Lost;
  logic       Pending_1, Pending_2, Pending_3, Pending_4, Pending_5, Pending_6, Pending_7;
  logic       Valid;
  logic [7:0] Index;
  logic       Lost;

  typedef struct {
    logic [6:0] pending;
    logic       valid;
    logic [7:0] index;
    logic       lost;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state, indexed by channel number 1..7.
  bit m_prev[1:7];
  bit m_pend[1:7];
  bit m_mask[1:7];
  bit m_lost;

  always #5 clk = ~clk;

  event_latch_7ch dut (
    .clk        (clk),
    .rst        (rst),
    .Req_1      (rq[0]),
    .Req_2      (rq[1]),
    .Req_3      (rq[2]),
    .Req_4      (rq[3]),
    .Req_5      (rq[4]),
    .Req_6      (rq[5]),
    .Req_7      (rq[6]),
    .Mask_Load  (Mask_Load),
    .Mask_Data  (Mask_Data),
    .Ack        (Ack),
    .Clear_Lost (Clear_Lost),
    .Pending_1  (Pending_1),
    .Pending_2  (Pending_2),
    .Pending_3  (Pending_3),
    .Pending_4  (Pending_4),
    .Pending_5  (Pending_5),
    .Pending_6  (Pending_6),
    .Pending_7  (Pending_7),
    .Valid      (Valid),
    .Index      (Index),
    .Lost       (Lost)
  );

  function automatic int visible_channel();
    for (int c = 1; c <= 7; c++) begin
      if (m_pend[c] && m_mask[c]) return c;
    end
    return 0;
  endfunction

  function automatic obs_t model_outputs();
    obs_t o;
    int   v;
    o.pending = '0;
    for (int c = 1; c <= 7; c++) o.pending[c-1] = m_pend[c] & m_mask[c];
    v = visible_channel();
    o.valid = (v != 0);
    o.index = 8'(v);
    o.lost  = m_lost;
    return o;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, queue the expectation.
  task automatic step(input bit r, input logic [6:0] req_in, input bit ml, input logic [7:0] md,
                      input bit a, input bit cl);
    int ack_ch;
    bit new_loss;
    bit ev;
    rst = r; rq = req_in; Mask_Load = ml; Mask_Data = md; Ack = a; Clear_Lost = cl;
    if (r) begin
      for (int c = 1; c <= 7; c++) begin
        m_prev[c] = 0; m_pend[c] = 0; m_mask[c] = 1;
      end
      m_lost = 0;
    end else begin
      ack_ch   = a ? visible_channel() : 0;
      new_loss = 0;
      for (int c = 1; c <= 7; c++) begin
`ifdef EVENT_LATCH_LEVEL_EN
        ev = req_in[c-1];
`else
        ev = req_in[c-1] && !m_prev[c];
        if (ev && m_pend[c] && c != ack_ch) new_loss = 1;
`endif
        if (ev)               m_pend[c] = 1;
        else if (c == ack_ch) m_pend[c] = 0;
        m_prev[c] = req_in[c-1];
        if (ml) m_mask[c] = md[c-1];
      end
      if (new_loss) m_lost = 1;
      else if (cl)  m_lost = 0;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input logic [6:0] req_in);
    step(0, req_in, 0, 8'h00, 0, 0);
  endtask

  task automatic ack_once();
    step(0, 7'h00, 0, 8'h00, 1, 0);
  endtask

  // Monitor: outputs are registered, so each queued expectation is compared mid-cycle.
  initial begin
    obs_t e;
    obs_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act.pending = {Pending_7, Pending_6, Pending_5, Pending_4, Pending_3, Pending_2, Pending_1};
        act.valid   = Valid;
        act.index   = Index;
        act.lost    = Lost;
        n_checks++;
        if (act.pending !== e.pending || act.valid !== e.valid ||
            act.index !== e.index || act.lost !== e.lost) begin
          n_fail++;
          $display("FAIL outputs @%0t: got pend=%b valid=%b index=%0d lost=%b, want pend=%b valid=%b index=%0d lost=%b",
                   $time, act.pending, act.valid, act.index, act.lost,
                   e.pending, e.valid, e.index, e.lost);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rq = '0; Mask_Load = 0; Mask_Data = '0; Ack = 0; Clear_Lost = 0;
    @(posedge clk);
    #1;
    step(1, 7'h00, 0, 8'h00, 0, 0);
    step(1, 7'h7F, 1, 8'h00, 1, 1);   // inputs ignored during reset

    // Single pulse on channel 3, then retire it.
    idle(7'b0000100);
    ack_once();
    idle(7'h00);

    // Channels 5 and 2 together: retired 2, then 5, back to back.
    idle(7'b0010010);
    ack_once();
    ack_once();
    ack_once();

    // Masked capture becomes visible on unmask.
    step(0, 7'h00, 1, 8'h7B, 0, 0);
    idle(7'b0000100);
    idle(7'h00);
    step(0, 7'h00, 1, 8'h7F, 0, 0);
    ack_once();

    // Lost on channel 4, clear, and set-beats-clear.
    idle(7'b0001000);
    idle(7'h00);
    idle(7'b0001000);
    idle(7'h00);
    step(0, 7'h00, 0, 8'h00, 0, 1);
    step(0, 7'b0001000, 0, 8'h00, 0, 1);
    step(0, 7'h00, 0, 8'h00, 0, 1);
    ack_once();

    // Ack of channel 6 coinciding with a new rise on channel 6.
    idle(7'b0100000);
    idle(7'h00);
    step(0, 7'b0100000, 0, 8'h00, 1, 0);
    idle(7'h00);
    ack_once();

    // Req_1 held high across a reset pulse, then Ack while it stays high.
    idle(7'b0000001);
    step(1, 7'b0000001, 0, 8'h00, 0, 0);
    idle(7'b0000001);
    idle(7'b0000001);
    step(0, 7'b0000001, 0, 8'h00, 1, 0);
    idle(7'b0000001);
    idle(7'h00);
    ack_once();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [6:0] r;
      r = 7'($urandom) & 7'($urandom) & 7'($urandom);
      step(($urandom_range(0, 99) == 0), r,
           ($urandom_range(0, 9) == 0), 8'($urandom),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
    end

    idle(7'h00);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
